// File: rtl/toysram_pkg.sv
// toysram_pkg: shared FSM encoding, requester IDs and default base address for the toy SRAM controller
package toysram_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, WAIT = 2'd2, DONE = 2'd3} state_e;
  localparam logic REQ_WB = 1'b0;
  localparam logic REQ_LA = 1'b1;
  localparam logic [31:0] DEF_BASE_ADR = 32'h3000_0000;
endpackage

// File: rtl/toysram_rr_arb2.sv
// toysram_rr_arb2: two-requester round-robin arbiter; on a tie the requester not granted last wins
module toysram_rr_arb2
  import toysram_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [1:0] req_i,
  input  logic       adv_i,
  output logic [1:0] gnt_o
);
  logic last_q;
  assign gnt_o = (&req_i) ? ((last_q == REQ_LA) ? 2'b01 : 2'b10) : req_i;
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) last_q <= REQ_LA;
    else if (adv_i && |req_i) last_q <= gnt_o[REQ_LA];
endmodule

// File: rtl/toysram_arb_ctl.sv
// toysram_arb_ctl: sequences a single-port SRAM shared round-robin between Wishbone and a test port
module toysram_arb_ctl
  import toysram_pkg::*;
#(
  parameter logic [31:0] BASE_ADR = DEF_BASE_ADR,
  parameter int ADR_W  = 8,
  parameter int DAT_W  = 32,
  parameter int RD_LAT = 1
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_i,
  input  logic             wbs_cyc_i,
  input  logic             wbs_stb_i,
  input  logic             wbs_we_i,
  input  logic [3:0]       wbs_sel_i,
  input  logic [31:0]      wbs_adr_i,
  input  logic [DAT_W-1:0] wbs_dat_i,
  output logic             wbs_ack_o,
  output logic [DAT_W-1:0] wbs_dat_o,
  input  logic             la_req_i,
  input  logic             la_we_i,
  input  logic [ADR_W-1:0] la_adr_i,
  input  logic [DAT_W-1:0] la_dat_i,
  output logic             la_gnt_o,
  output logic             la_rvld_o,
  output logic [DAT_W-1:0] la_rdat_o,
  output logic             sram_ce_o,
  output logic             sram_we_o,
  output logic [3:0]       sram_wmask_o,
  output logic [ADR_W-1:0] sram_adr_o,
  output logic [DAT_W-1:0] sram_wdat_o,
  input  logic [DAT_W-1:0] sram_rdat_i
);
  if (RD_LAT < 1 || RD_LAT > 3) begin : g_bad_lat
    $error("toysram_arb_ctl: RD_LAT must be 1..3");
  end
  state_e state_q, state_d;
  logic [1:0] cnt_q, cnt_d;
  logic own_q, own_d;
  logic ce_q, ce_d, we_q, we_d, ack_q, ack_d, gnt_q, gnt_d, rvld_q, rvld_d;
  logic [3:0] mask_q, mask_d;
  logic [ADR_W-1:0] adr_q, adr_d;
  logic [DAT_W-1:0] wdat_q, wdat_d, rdat_q, rdat_d, lrdat_q, lrdat_d;
  logic [1:0] gnt;
  logic wb_req, unused_adr;
  assign unused_adr = ^wbs_adr_i[1:0];
  assign wb_req = wbs_cyc_i & wbs_stb_i & (wbs_adr_i[31:ADR_W+2] == BASE_ADR[31:ADR_W+2]);
  toysram_rr_arb2 u_arb (
    .clk_i(wb_clk_i),
    .rst_i(wb_rst_i),
    .req_i({la_req_i, wb_req}),
    .adv_i(state_q == IDLE),
    .gnt_o(gnt)
  );
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    own_d   = own_q;
    ce_d    = 1'b0;
    we_d    = 1'b0;
    mask_d  = 4'h0;
    adr_d   = adr_q;
    wdat_d  = wdat_q;
    ack_d   = 1'b0;
    rdat_d  = '0;
    gnt_d   = 1'b0;
    rvld_d  = 1'b0;
    lrdat_d = lrdat_q;
    case (state_q)
      IDLE: if (|gnt) begin
        own_d   = gnt[REQ_LA];
        ce_d    = 1'b1;
        we_d    = own_d ? la_we_i : wbs_we_i;
        mask_d  = own_d ? 4'hF : wbs_sel_i;
        adr_d   = own_d ? la_adr_i : wbs_adr_i[ADR_W+1:2];
        wdat_d  = own_d ? la_dat_i : wbs_dat_i;
        gnt_d   = own_d;
        state_d = ISSUE;
      end
      ISSUE: begin
        state_d = we_q ? DONE : WAIT;
        cnt_d   = 2'(RD_LAT - 1);
        ack_d   = we_q & ~own_q & wbs_cyc_i;
      end
      WAIT: if (cnt_q == 2'd0) begin
        // Response flags are registered here so they are visible during DONE.
        state_d = DONE;
        rvld_d  = own_q;
        lrdat_d = own_q ? sram_rdat_i : lrdat_q;
        ack_d   = ~own_q & wbs_cyc_i;
        rdat_d  = (~own_q & wbs_cyc_i) ? sram_rdat_i : '0;
      end else cnt_d = cnt_q - 2'd1;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge wb_clk_i or posedge wb_rst_i)
    if (wb_rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      own_q   <= 1'b0;
      ce_q    <= 1'b0;
      we_q    <= 1'b0;
      mask_q  <= '0;
      adr_q   <= '0;
      wdat_q  <= '0;
      ack_q   <= 1'b0;
      rdat_q  <= '0;
      gnt_q   <= 1'b0;
      rvld_q  <= 1'b0;
      lrdat_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      own_q   <= own_d;
      ce_q    <= ce_d;
      we_q    <= we_d;
      mask_q  <= mask_d;
      adr_q   <= adr_d;
      wdat_q  <= wdat_d;
      ack_q   <= ack_d;
      rdat_q  <= rdat_d;
      gnt_q   <= gnt_d;
      rvld_q  <= rvld_d;
      lrdat_q <= lrdat_d;
    end
  assign sram_ce_o    = ce_q;
  assign sram_we_o    = we_q;
  assign sram_wmask_o = mask_q;
  assign sram_adr_o   = adr_q;
  assign sram_wdat_o  = wdat_q;
  assign wbs_ack_o    = ack_q;
  assign wbs_dat_o    = rdat_q;
  assign la_gnt_o     = gnt_q;
  assign la_rvld_o    = rvld_q;
  assign la_rdat_o    = lrdat_q;
endmodule

// File: tb/tb_toysram_arb_ctl.sv
// tb_toysram_arb_ctl: directed self-checking bench for toysram_arb_ctl with RD_LAT=2 and a behavioural SRAM
module tb_toysram_arb_ctl;
  logic clk = 1'b0, rst = 1'b1;
  logic cyc = 0, stb = 0, we = 0;
  logic [3:0] sel = 0;
  logic [31:0] adr = 0, dat = 0;
  logic ack;
  logic [31:0] rdat;
  logic la_req = 0, la_we = 0;
  logic [7:0] la_adr = 0;
  logic [31:0] la_dat = 0;
  logic la_gnt, la_rvld;
  logic [31:0] la_rdat;
  logic ce, swe;
  logic [3:0] wmask;
  logic [7:0] sadr;
  logic [31:0] swdat, srdat;
  int n_cmp = 0, n_err = 0;
  always #5 clk = ~clk;
  toysram_arb_ctl #(.RD_LAT(2)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .wbs_cyc_i(cyc), .wbs_stb_i(stb), .wbs_we_i(we), .wbs_sel_i(sel),
    .wbs_adr_i(adr), .wbs_dat_i(dat), .wbs_ack_o(ack), .wbs_dat_o(rdat),
    .la_req_i(la_req), .la_we_i(la_we), .la_adr_i(la_adr), .la_dat_i(la_dat),
    .la_gnt_o(la_gnt), .la_rvld_o(la_rvld), .la_rdat_o(la_rdat),
    .sram_ce_o(ce), .sram_we_o(swe), .sram_wmask_o(wmask), .sram_adr_o(sadr),
    .sram_wdat_o(swdat), .sram_rdat_i(srdat)
  );
  // SRAM model: masked writes, reads valid two cycles after the access cycle
  logic [31:0] mem [256];
  logic [31:0] p1, p2;
  logic v1 = 0, v2 = 0;
  initial for (int i = 0; i < 256; i++) mem[i] = 32'h0;
  always @(posedge clk) begin
    if (ce && swe)
      for (int b = 0; b < 4; b++) if (wmask[b]) mem[sadr][8*b +: 8] <= swdat[8*b +: 8];
    v1 <= ce && !swe;
    p1 <= mem[sadr];
    v2 <= v1;
    p2 <= p1;
  end
  assign srdat = v2 ? p2 : 32'hBAD0_BAD0;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic test_reset();
    repeat (2) tick();
    n_cmp++; if ({ack, rdat, la_gnt, la_rvld, la_rdat, ce, swe, wmask, sadr, swdat} !== '0) begin n_err++; $display("FAIL reset_outputs got nonzero outputs ack=%b ce=%b want all 0", ack, ce); end
    rst = 1'b0;
    tick();
    n_cmp++; if (ce !== 1'b0) begin n_err++; $display("FAIL idle_ce got %b want 0", ce); end
  endtask
  task automatic test_write();
    cyc = 1; stb = 1; we = 1; sel = 4'hF; adr = 32'h3000_0010; dat = 32'hDEAD_BEEF;
    tick();
    n_cmp++; if ({ce, swe, wmask, sadr, swdat, ack} !== {1'b1, 1'b1, 4'hF, 8'h04, 32'hDEAD_BEEF, 1'b0}) begin n_err++; $display("FAIL wr_issue got ce=%b we=%b m=%h a=%h d=%h ack=%b want 1 1 f 04 deadbeef 0", ce, swe, wmask, sadr, swdat, ack); end
    tick();
    n_cmp++; if ({ack, rdat, ce, swe, wmask} !== {1'b1, 32'h0, 1'b0, 1'b0, 4'h0}) begin n_err++; $display("FAIL wr_ack got ack=%b dat=%h ce=%b we=%b m=%h want 1 0 0 0 0", ack, rdat, ce, swe, wmask); end
    cyc = 0; stb = 0; we = 0;
    tick();
    n_cmp++; if (ack !== 1'b0) begin n_err++; $display("FAIL wr_ack_drop got %b want 0", ack); end
  endtask
  task automatic test_read(input logic [31:0] exp, input string nm);
    cyc = 1; stb = 1; we = 0; sel = 4'hF; adr = 32'h3000_0010;
    for (int t = 1; t <= 5; t++) begin
      tick();
      if (t == 1) begin
        n_cmp++; if ({ce, swe, sadr} !== {1'b1, 1'b0, 8'h04}) begin n_err++; $display("FAIL %s_issue got ce=%b we=%b a=%h want 1 0 04", nm, ce, swe, sadr); end
      end
      if (t == 4) begin
        n_cmp++; if ({ack, rdat} !== {1'b1, exp}) begin n_err++; $display("FAIL %s_ack got ack=%b dat=%h want 1 %h", nm, ack, rdat, exp); end
        cyc = 0; stb = 0;
      end else begin
        n_cmp++; if ({ack, rdat} !== 33'h0) begin n_err++; $display("FAIL %s_idle_c%0d got ack=%b dat=%h want 0 0", nm, t, ack, rdat); end
      end
    end
  endtask
  task automatic test_byte_write();
    cyc = 1; stb = 1; we = 1; sel = 4'b0100; adr = 32'h3000_0010; dat = 32'h00AB_0000;
    tick();
    n_cmp++; if ({ce, swe, wmask, sadr} !== {1'b1, 1'b1, 4'b0100, 8'h04}) begin n_err++; $display("FAIL bw_issue got ce=%b we=%b m=%b a=%h want 1 1 0100 04", ce, swe, wmask, sadr); end
    tick();
    n_cmp++; if (ack !== 1'b1) begin n_err++; $display("FAIL bw_ack got %b want 1", ack); end
    cyc = 0; stb = 0; we = 0;
    tick();
    test_read(32'hDEAB_BEEF, "bw_rd");
  endtask
  task automatic test_la_read();
    la_req = 1; la_we = 0; la_adr = 8'h04;
    tick();
    n_cmp++; if ({la_gnt, ce, swe, wmask, sadr} !== {1'b1, 1'b1, 1'b0, 4'hF, 8'h04}) begin n_err++; $display("FAIL la_rd_issue got g=%b ce=%b we=%b m=%h a=%h want 1 1 0 f 04", la_gnt, ce, swe, wmask, sadr); end
    la_req = 0;
    repeat (2) tick();
    n_cmp++; if (la_rvld !== 1'b0) begin n_err++; $display("FAIL la_rvld_early got %b want 0", la_rvld); end
    tick();
    n_cmp++; if ({la_rvld, la_rdat, ack} !== {1'b1, 32'hDEAB_BEEF, 1'b0}) begin n_err++; $display("FAIL la_rvld got v=%b d=%h ack=%b want 1 deabbeef 0", la_rvld, la_rdat, ack); end
    tick();
    n_cmp++; if ({la_rvld, la_rdat} !== {1'b0, 32'hDEAB_BEEF}) begin n_err++; $display("FAIL la_rdat_hold got v=%b d=%h want 0 deabbeef", la_rvld, la_rdat); end
  endtask
  task automatic test_back_to_back();
    logic [11:0] exp_issue, exp_gnt, exp_ack;
    exp_issue = 12'b0100_1001_0010;
    exp_gnt   = 12'b0100_0001_0000;
    exp_ack   = 12'b0001_0000_0100;
    cyc = 1; stb = 1; we = 1; sel = 4'hF; adr = 32'h3000_0020; dat = 32'h2222_2222;
    la_req = 1; la_we = 1; la_adr = 8'h10; la_dat = 32'h1111_1111;
    for (int t = 1; t <= 11; t++) begin
      tick();
      n_cmp++; if ({ce, la_gnt, ack} !== {exp_issue[t], exp_gnt[t], exp_ack[t]}) begin n_err++; $display("FAIL arb_c%0d got ce=%b gnt=%b ack=%b want %b %b %b", t, ce, la_gnt, ack, exp_issue[t], exp_gnt[t], exp_ack[t]); end
      if (exp_issue[t]) begin
        n_cmp++; if (sadr !== (exp_gnt[t] ? 8'h10 : 8'h08)) begin n_err++; $display("FAIL arb_adr_c%0d got %h want %h", t, sadr, exp_gnt[t] ? 8'h10 : 8'h08); end
      end
      if (t == 10) begin la_req = 0; cyc = 0; stb = 0; we = 0; end
    end
    n_cmp++; if (la_rvld !== 1'b0) begin n_err++; $display("FAIL arb_la_wr_rvld got %b want 0", la_rvld); end
    tick();
  endtask
  task automatic test_miss();
    cyc = 1; stb = 1; we = 1; sel = 4'hF; adr = 32'h2000_0000; dat = 32'h5555_5555;
    for (int t = 0; t < 10; t++) begin
      tick();
      n_cmp++; if ({ce, ack} !== 2'b00) begin n_err++; $display("FAIL miss_c%0d got ce=%b ack=%b want 0 0", t, ce, ack); end
    end
    cyc = 0; stb = 0; we = 0;
    tick();
  endtask
  task automatic test_abort_reset();
    cyc = 1; stb = 1; we = 0; adr = 32'h3000_0010;
    tick();
    n_cmp++; if (ce !== 1'b1) begin n_err++; $display("FAIL ab_issue got %b want 1", ce); end
    tick();
    cyc = 0; stb = 0;
    for (int t = 3; t <= 6; t++) begin
      tick();
      n_cmp++; if ({ack, rdat} !== 33'h0) begin n_err++; $display("FAIL ab_noack_c%0d got ack=%b dat=%h want 0 0", t, ack, rdat); end
    end
    la_req = 1; la_we = 1; la_adr = 8'h30; la_dat = 32'h7777_7777;
    tick();
    n_cmp++; if ({la_gnt, ce, swe} !== 3'b111) begin n_err++; $display("FAIL rst_pre_issue got g=%b ce=%b we=%b want 1 1 1", la_gnt, ce, swe); end
    #2 rst = 1'b1;
    #1;
    n_cmp++; if ({ack, rdat, la_gnt, la_rvld, la_rdat, ce, swe, wmask, sadr, swdat} !== '0) begin n_err++; $display("FAIL rst_async got g=%b ce=%b we=%b lrd=%h a=%h want all 0", la_gnt, ce, swe, la_rdat, sadr); end
    la_req = 0;
    tick();
    rst = 1'b0;
    tick();
    n_cmp++; if (ce !== 1'b0) begin n_err++; $display("FAIL rst_idle got ce=%b want 0", ce); end
    test_read(32'hDEAB_BEEF, "post_rst_rd");
  endtask
  initial begin
    test_reset();
    test_write();
    test_read(32'hDEAD_BEEF, "rd");
    test_byte_write();
    test_la_read();
    test_back_to_back();
    test_miss();
    test_abort_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
